// File: rtl/vec_mem_responder_pkg.sv
// Shared types for the vector M-stage memory responder and the datapath.
package vec_mem_pkg;

  localparam int LANES  = 6;
  localparam int LANE_W = 8;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} vmr_state_t;

  typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

endpackage

// File: rtl/vec_mem_responder_if.sv
// M-stage data port between the vector datapath (master) and the memory responder (slave).
interface vec_mem_responder_if #(
  parameter int I = 32
);
  import vec_mem_pkg::*;

  logic         MemWriteM;
  logic         ReadReqM;
  logic [I-1:0] AddressM;
  vec_t         WriteDataM;
  vec_t         ReadData;
  logic         StallM;

  modport master (
    output MemWriteM, ReadReqM, AddressM, WriteDataM,
    input  ReadData, StallM
  );

  modport slave (
    input  MemWriteM, ReadReqM, AddressM, WriteDataM,
    output ReadData, StallM
  );
endinterface

// File: rtl/vec_mem_responder_gather.sv
// Collects load bytes into a shadow register and commits the full vector to ReadData in one edge.
module vec_lane_gather
  import vec_mem_pkg::*;
#(
  parameter int N  = LANE_W,
  parameter int R  = LANES,
  parameter int KW = $clog2(R)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cap_en,
  input  logic [KW-1:0]         lane_idx,
  input  logic [N-1:0]          byte_in,
  input  logic                  commit,
  output logic [R-1:0][N-1:0]   rdata
);

  logic [R-2:0][N-1:0] shadow_q, shadow_d;
  logic [R-1:0][N-1:0] rdata_q, rdata_d;

  genvar gi;
  generate
    for (gi = 0; gi < R - 1; gi++) begin : g_shadow
      assign shadow_d[gi] = (cap_en && (lane_idx == KW'(gi))) ? byte_in : shadow_q[gi];
    end
  endgenerate

  // The last lane never passes through the shadow: it arrives on the commit cycle itself.
  always_comb begin
    rdata_d = rdata_q;
    if (commit) begin
      rdata_d = {byte_in, shadow_q};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_q <= '0;
      rdata_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vec_mem_responder.sv
// Serialises R-lane vector loads/stores into byte accesses on a single-port synchronous RAM.
module vec_mem_responder
  import vec_mem_pkg::*;
#(
  parameter int I  = 32,
  parameter int N  = LANE_W,
  parameter int R  = LANES,
  parameter int AW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  vec_mem_responder_if.slave   m,
  output logic [AW-1:0]        ram_addr,
  output logic [N-1:0]         ram_wdata,
  output logic                 ram_we,
  input  logic [N-1:0]         ram_rdata
);

  localparam int KW = $clog2(R);

  vmr_state_t           state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [AW-1:0]        base_q, base_d;
  logic [R-1:0][N-1:0]  wbuf_q, wbuf_d;

  logic [I-1:0]  addr_in;
  logic          addr_unused;
  logic          req;
  logic          last_lane;
  logic          stall;
  logic          cap_en;
  logic          commit;
  logic [KW-1:0] lane_idx;

  assign addr_in     = m.AddressM;
  assign addr_unused = ^addr_in[I-1:AW];
  assign req         = m.MemWriteM | m.ReadReqM;
  assign last_lane   = (k_q == KW'(R - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      base_q  <= '0;
      wbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      base_q  <= base_d;
      wbuf_q  <= wbuf_d;
    end
  end

  // A store takes priority when both requests are raised together.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    base_d  = base_q;
    wbuf_d  = wbuf_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          base_d  = addr_in[AW-1:0];
          wbuf_d  = m.WriteDataM;
          k_d     = '0;
          state_d = m.MemWriteM ? WRITE : READ;
        end
      end
      WRITE: begin
        if (last_lane) begin
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      READ: begin
        if (last_lane) begin
          k_d     = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM-side outputs depend only on registered state; reset forces everything quiet.
  always_comb begin
    stall     = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = base_q;
    ram_wdata = '0;
    cap_en    = 1'b0;
    commit    = 1'b0;
    lane_idx  = k_q - KW'(1);
    case (state_q)
      IDLE:  stall = req;
      WRITE: begin
        stall     = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = base_q + AW'(k_q);
        ram_wdata = wbuf_q[k_q];
      end
      READ: begin
        stall    = 1'b1;
        ram_addr = base_q + AW'(k_q);
        cap_en   = (k_q != '0);
      end
      DRAIN: begin
        stall  = 1'b1;
        commit = 1'b1;
      end
      default: ;
    endcase
    if (!reset) begin
      stall     = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      cap_en    = 1'b0;
      commit    = 1'b0;
    end
  end

  assign m.StallM = stall;

  vec_lane_gather #(
    .N  (N),
    .R  (R),
    .KW (KW)
  ) u_gather (
    .clk      (clk),
    .reset    (reset),
    .cap_en   (cap_en),
    .lane_idx (lane_idx),
    .byte_in  (ram_rdata),
    .commit   (commit),
    .rdata    (m.ReadData)
  );

endmodule

// File: tb/tb_vec_mem_responder.sv
// Directed bench for vec_mem_responder against a behavioural byte RAM with 1-cycle read latency.
module tb_vec_mem_responder;
  import vec_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        ram_we;

  logic [7:0]  mem [0:65535];
  int          we_count = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  vec_mem_responder_if #(.I(32)) mif ();

  vec_mem_responder #(.I(32), .N(8), .R(6), .AW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .m         (mif),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      we_count++;
    end
    ram_rdata <= mem[ram_addr];
  end

  // Called just after a rising edge with the DUT in IDLE; returns at the falling edge of DONE
  // with the request still asserted, so the caller can look at DONE-cycle outputs.
  task automatic access(input logic we, input logic re, input logic [31:0] addr,
                        input vec_t wd, output int stalls);
    mif.MemWriteM  = we;
    mif.ReadReqM   = re;
    mif.AddressM   = addr;
    mif.WriteDataM = wd;
    stalls = 0;
    @(negedge clk);
    while (mif.StallM === 1'b1 && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
  endtask

  task automatic release_req;
    @(posedge clk);
    #1;
    mif.MemWriteM = 1'b0;
    mif.ReadReqM  = 1'b0;
  endtask

  task automatic test_reset;
    mif.MemWriteM  = 1'b1;
    mif.ReadReqM   = 1'b0;
    mif.AddressM   = 32'h0000_0010;
    mif.WriteDataM = '0;
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (mif.StallM !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 16'h0 || mif.ReadData !== '0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got stall=%b we=%b addr=%h rd=%h want 0,0,0000,0",
                 c, mif.StallM, ram_we, ram_addr, mif.ReadData);
      end
    end
    @(posedge clk);
    #1;
    mif.MemWriteM = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (dut.state_q !== IDLE || mif.StallM !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got state=%0d stall=%b want IDLE,0", dut.state_q, mif.StallM);
    end
    $display("reset: held 2 cycles with store request, released");
    @(posedge clk);
    #1;
  endtask

  task automatic test_store;
    vec_t d;
    int   st, w0;
    d  = {8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    w0 = we_count;
    access(1'b1, 1'b0, 32'h0000_0010, d, st);
    checks++;
    if (st !== 7) begin
      failures++;
      $display("FAIL store_stall got %0d want 7", st);
    end
    release_req();
    checks++;
    if (we_count - w0 !== 6) begin
      failures++;
      $display("FAIL store_we_pulses got %0d want 6", we_count - w0);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (mem[16'h0010 + 16'(k)] !== d[k]) begin
        failures++;
        $display("FAIL store_byte%0d got %h want %h", k, mem[16'h0010 + 16'(k)], d[k]);
      end
    end
    $display("store: addr=00000010 data=%h stalls=%0d", d, st);
  endtask

  task automatic test_load;
    vec_t d;
    int   st;
    logic bad;
    d = {8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    access(1'b0, 1'b1, 32'h0000_0010, '0, st);
    checks++;
    if (st !== 8) begin
      failures++;
      $display("FAIL load_stall got %0d want 8", st);
    end
    checks++;
    if (mif.ReadData !== d) begin
      failures++;
      $display("FAIL load_data got %h want %h", mif.ReadData, d);
    end
    release_req();
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mif.ReadData !== d) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL load_hold got %h want %h", mif.ReadData, d);
    end
    $display("load: addr=00000010 data=%h stalls=%0d", mif.ReadData, st);
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap;
    vec_t        d;
    int          st;
    logic [15:0] exp_a [6];
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003};
    d = {8'hA6, 8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1};
    access(1'b1, 1'b0, 32'h1234_FFFE, d, st);
    checks++;
    if (st !== 7) begin
      failures++;
      $display("FAIL wrap_store_stall got %0d want 7", st);
    end
    release_req();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (mem[exp_a[k]] !== d[k]) begin
        failures++;
        $display("FAIL wrap_byte%0d addr=%h got %h want %h", k, exp_a[k], mem[exp_a[k]], d[k]);
      end
    end
    $display("wrap store: addr=1234fffe data=%h stalls=%0d", d, st);
    access(1'b0, 1'b1, 32'h1234_FFFE, '0, st);
    checks++;
    if (st !== 8 || mif.ReadData !== d) begin
      failures++;
      $display("FAIL wrap_load got stalls=%0d data=%h want 8,%h", st, mif.ReadData, d);
    end
    release_req();
    $display("wrap load: addr=1234fffe data=%h stalls=%0d", mif.ReadData, st);
  endtask

  task automatic test_back_to_back;
    vec_t d;
    int   st, w0;
    d  = {8'hB6, 8'hB5, 8'hB4, 8'hB3, 8'hB2, 8'hB1};
    w0 = we_count;
    access(1'b1, 1'b0, 32'h0000_0040, d, st);
    checks++;
    if (st !== 7) begin
      failures++;
      $display("FAIL b2b_store_stall got %0d want 7", st);
    end
    $display("b2b store: addr=00000040 data=%h stalls=%0d", d, st);
    @(posedge clk);
    #1;
    access(1'b0, 1'b1, 32'h0000_0040, '0, st);
    checks++;
    if (st !== 8) begin
      failures++;
      $display("FAIL b2b_load_stall got %0d want 8", st);
    end
    checks++;
    if (we_count - w0 !== 6) begin
      failures++;
      $display("FAIL b2b_we_pulses got %0d want 6", we_count - w0);
    end
    checks++;
    if (mif.ReadData !== d) begin
      failures++;
      $display("FAIL b2b_load_data got %h want %h", mif.ReadData, d);
    end
    release_req();
    $display("b2b load: addr=00000040 data=%h stalls=%0d", mif.ReadData, st);
  endtask

  task automatic test_both;
    vec_t d, prev;
    int   st, w0;
    d    = {8'hC6, 8'hC5, 8'hC4, 8'hC3, 8'hC2, 8'hC1};
    prev = {8'hB6, 8'hB5, 8'hB4, 8'hB3, 8'hB2, 8'hB1};
    w0   = we_count;
    access(1'b1, 1'b1, 32'h0000_0080, d, st);
    checks++;
    if (st !== 7) begin
      failures++;
      $display("FAIL both_stall got %0d want 7", st);
    end
    checks++;
    if (mif.ReadData !== prev) begin
      failures++;
      $display("FAIL both_readdata got %h want %h", mif.ReadData, prev);
    end
    release_req();
    checks++;
    if (we_count - w0 !== 6 || mem[16'h0085] !== 8'hC6 || mem[16'h0080] !== 8'hC1) begin
      failures++;
      $display("FAIL both_written got pulses=%0d b0=%h b5=%h want 6,c1,c6",
               we_count - w0, mem[16'h0080], mem[16'h0085]);
    end
    $display("both: addr=00000080 data=%h stalls=%0d readdata=%h", d, st, mif.ReadData);
  endtask

  task automatic test_abort;
    vec_t fill, d;
    int   st;
    fill = {6{8'hEE}};
    d    = {8'hD6, 8'hD5, 8'hD4, 8'hD3, 8'hD2, 8'hD1};
    access(1'b1, 1'b0, 32'h0000_0200, fill, st);
    release_req();
    mif.MemWriteM  = 1'b1;
    mif.AddressM   = 32'h0000_0200;
    mif.WriteDataM = d;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (dut.state_q !== WRITE || dut.k_q !== 3'd3) begin
      failures++;
      $display("FAIL abort_phase got state=%0d k=%0d want WRITE,3", dut.state_q, dut.k_q);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b0 || mif.StallM !== 1'b0) begin
      failures++;
      $display("FAIL abort_gate got we=%b stall=%b want 0,0", ram_we, mif.StallM);
    end
    @(negedge clk);
    checks++;
    if (dut.state_q !== IDLE || mif.StallM !== 1'b0 || ram_we !== 1'b0 || mif.ReadData !== '0) begin
      failures++;
      $display("FAIL abort_state got state=%0d stall=%b we=%b rd=%h want IDLE,0,0,0",
               dut.state_q, mif.StallM, ram_we, mif.ReadData);
    end
    @(posedge clk);
    #1;
    mif.MemWriteM = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (mem[16'h0200 + 16'(k)] !== ((k < 3) ? d[k] : 8'hEE)) begin
        failures++;
        $display("FAIL abort_byte%0d got %h want %h", k, mem[16'h0200 + 16'(k)],
                 (k < 3) ? d[k] : 8'hEE);
      end
    end
    $display("abort: store addr=00000200 reset at k=3");
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_wrap();
    test_back_to_back();
    test_both();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
